// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA raster timing: sync, active flag, pixel coordinates and a per-frame strobe.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN; otherwise frameCount is tied to 0.
module vga_timing_generator #(
    parameter int WIDTH         = 640,
    parameter int HEIGHT        = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2,
    parameter int V_BACK_PORCH  = 33
) (
    input  logic        clk25,
    input  logic        reset,
    output logic        screenEnd,
    output logic        active,
    output logic        hSync,
    output logic        vSync,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [15:0] frameCount
);

    localparam int H_TOTAL = WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACTIVE     = 10'(WIDTH);
    localparam logic [9:0] V_ACTIVE     = 10'(HEIGHT);
    localparam logic [9:0] H_SYNC_START = 10'(WIDTH + H_FRONT_PORCH);
    localparam logic [9:0] H_SYNC_END   = 10'(WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0] V_SYNC_START = 10'(HEIGHT + V_FRONT_PORCH);
    localparam logic [9:0] V_SYNC_END   = 10'(HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH);

    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       started;

    // The first edge after reset release only arms the counters, so (0,0) is shown for a full cycle.
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            hCount  <= '0;
            vCount  <= '0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (started) begin
                if (hCount == H_LAST) begin
                    hCount <= '0;
                    vCount <= (vCount == V_LAST) ? '0 : vCount + 10'd1;
                end else begin
                    hCount <= hCount + 10'd1;
                end
            end
        end
    end

    // Outputs are gated by reset directly so they are forced the moment reset goes low.
    always_comb begin
        active    = reset && (hCount < H_ACTIVE) && (vCount < V_ACTIVE);
        hSync     = !(reset && (hCount >= H_SYNC_START) && (hCount < H_SYNC_END));
        vSync     = !(reset && (vCount >= V_SYNC_START) && (vCount < V_SYNC_END));
        screenEnd = reset && (hCount == 10'd0) && (vCount == V_ACTIVE);
        x         = reset ? hCount : '0;
        y         = reset ? vCount[8:0] : '0;
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            frameCount <= '0;
        end else if (screenEnd) begin
            frameCount <= frameCount + 16'd1;
        end
    end
`else
    assign frameCount = '0;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: full-size instance for line timing, reduced-size instance for frame-level timing.
module tb_vga_timing_generator;

    logic clk25 = 1'b0;
    logic resetA;
    logic resetB;

    logic        screenEndA, activeA, hSyncA, vSyncA;
    logic [9:0]  xA;
    logic [8:0]  yA;
    logic [15:0] frameCountA;

    logic        screenEndB, activeB, hSyncB, vSyncB;
    logic [9:0]  xB;
    logic [8:0]  yB;
    logic [15:0] frameCountB;

    int checkCount = 0;
    int passCount  = 0;

    always #20 clk25 = ~clk25;

    vga_timing_generator dutA (
        .clk25(clk25), .reset(resetA), .screenEnd(screenEndA), .active(activeA),
        .hSync(hSyncA), .vSync(vSyncA), .x(xA), .y(yA), .frameCount(frameCountA)
    );

    // Small raster: 30 clocks per line, 12 lines per frame, 360 clocks per frame.
    vga_timing_generator #(
        .WIDTH(20), .HEIGHT(6), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(5),
        .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(3)
    ) dutB (
        .clk25(clk25), .reset(resetB), .screenEnd(screenEndB), .active(activeB),
        .hSync(hSyncB), .vSync(vSyncB), .x(xB), .y(yB), .frameCount(frameCountB)
    );

    typedef struct {
        int         cyc;
        logic [9:0] expX;
        logic [8:0] expY;
        logic       expActive;
        logic       expHSync;
    } vecT;

    vecT vecs[10];

    task automatic applyStimulus();
        @(posedge clk25);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkForced(input string tag, input logic act, input logic hs, input logic vs,
                               input logic se, input logic [9:0] xv, input logic [8:0] yv,
                               input logic [15:0] fc);
        checkOutput({tag, " active"}, int'(act), 0);
        checkOutput({tag, " hSync"}, int'(hs), 1);
        checkOutput({tag, " vSync"}, int'(vs), 1);
        checkOutput({tag, " screenEnd"}, int'(se), 0);
        checkOutput({tag, " x"}, int'(xv), 0);
        checkOutput({tag, " y"}, int'(yv), 0);
        checkOutput({tag, " frameCount"}, int'(fc), 0);
    endtask

    initial begin
        int kA;
        int seK[3];
        int seNum;
        int vLow;
        int actNum;
        int expFrames;
        int budget;
        bit found;

        vecs[0] = '{1,   10'd0,   9'd0, 1'b1, 1'b1};
        vecs[1] = '{2,   10'd1,   9'd0, 1'b1, 1'b1};
        vecs[2] = '{3,   10'd2,   9'd0, 1'b1, 1'b1};
        vecs[3] = '{640, 10'd639, 9'd0, 1'b1, 1'b1};
        vecs[4] = '{641, 10'd640, 9'd0, 1'b0, 1'b1};
        vecs[5] = '{656, 10'd655, 9'd0, 1'b0, 1'b1};
        vecs[6] = '{657, 10'd656, 9'd0, 1'b0, 1'b0};
        vecs[7] = '{752, 10'd751, 9'd0, 1'b0, 1'b0};
        vecs[8] = '{753, 10'd752, 9'd0, 1'b0, 1'b1};
        vecs[9] = '{801, 10'd0,   9'd1, 1'b1, 1'b1};

        `ifdef VGA_FRAME_COUNT_EN
        expFrames = 3;
        `else
        expFrames = 0;
        `endif

        resetA = 1'b1;
        resetB = 1'b1;
        #5;
        resetA = 1'b0;
        resetB = 1'b0;
        repeat (10) applyStimulus();
        checkForced("resetA", activeA, hSyncA, vSyncA, screenEndA, xA, yA, frameCountA);
        checkForced("resetB", activeB, hSyncB, vSyncB, screenEndB, xB, yB, frameCountB);

        // Full-size line timing, table driven.
        @(negedge clk25);
        resetA = 1'b1;
        kA = 0;
        for (int i = 0; i < 10; i++) begin
            while (kA < vecs[i].cyc) begin
                applyStimulus();
                kA++;
            end
            checkOutput($sformatf("lineA k=%0d x", vecs[i].cyc), int'(xA), int'(vecs[i].expX));
            checkOutput($sformatf("lineA k=%0d y", vecs[i].cyc), int'(yA), int'(vecs[i].expY));
            checkOutput($sformatf("lineA k=%0d active", vecs[i].cyc), int'(activeA), int'(vecs[i].expActive));
            checkOutput($sformatf("lineA k=%0d hSync", vecs[i].cyc), int'(hSyncA), int'(vecs[i].expHSync));
        end
        checkForced("heldB", activeB, hSyncB, vSyncB, screenEndB, xB, yB, frameCountB);

        // Reduced-size frame timing over three frames.
        @(negedge clk25);
        resetB = 1'b1;
        seNum = 0;
        vLow = 0;
        actNum = 0;
        for (int k = 1; k <= 905; k++) begin
            applyStimulus();
            if (screenEndB === 1'b1) begin
                if (seNum < 3) seK[seNum] = k;
                seNum++;
            end
            if (k <= 360) begin
                if (vSyncB === 1'b0) vLow++;
                if (activeB === 1'b1) actNum++;
            end
            if (k == 22) checkOutput("frameB hSync before sync", int'(hSyncB), 1);
            if (k == 23) checkOutput("frameB hSync at sync start", int'(hSyncB), 0);
            if (k == 26) checkOutput("frameB hSync after sync", int'(hSyncB), 1);
            if (k == 360) begin
                checkOutput("frameB last x", int'(xB), 29);
                checkOutput("frameB last y", int'(yB), 11);
            end
            if (k == 361) begin
                checkOutput("frameB wrap x", int'(xB), 0);
                checkOutput("frameB wrap y", int'(yB), 0);
                checkOutput("frameB wrap active", int'(activeB), 1);
            end
            if (k == 182) checkOutput("frameB frameCount after first", int'(frameCountB), (expFrames == 3) ? 1 : 0);
        end
        checkOutput("frameB screenEnd pulses", seNum, 3);
        checkOutput("frameB first screenEnd", seK[0], 181);
        checkOutput("frameB second screenEnd", seK[1], 541);
        checkOutput("frameB third screenEnd", seK[2], 901);
        checkOutput("frameB vSync low cycles", vLow, 60);
        checkOutput("frameB active cycles", actNum, 120);
        checkOutput("frameB frameCount", int'(frameCountB), expFrames);
        checkOutput("lineA frameCount", int'(frameCountA), 0);

        // Mid-frame reset at (10,3), then the restart must reach screenEnd 181 edges after release.
        budget = 0;
        found = 1'b0;
        while (budget < 400 && !found) begin
            applyStimulus();
            budget++;
            if (xB == 10'd10 && yB == 9'd3) found = 1'b1;
        end
        checkOutput("midB reach (10,3)", int'(found), 1);
        resetB = 1'b0;
        #1;
        checkForced("midB", activeB, hSyncB, vSyncB, screenEndB, xB, yB, frameCountB);
        repeat (3) applyStimulus();
        @(negedge clk25);
        resetB = 1'b1;
        budget = 0;
        found = 1'b0;
        while (budget < 1000 && !found) begin
            applyStimulus();
            budget++;
            if (screenEndB === 1'b1) found = 1'b1;
        end
        checkOutput("midB restart screenEnd edge", found ? budget : -1, 181);
        checkOutput("midB restart x", int'(xB), 0);
        checkOutput("midB restart y", int'(yB), 6);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Generates 640×480 @ 60 Hz VGA raster timing from a 25 MHz pixel clock. It produces horizontal and vertical sync, a display-active flag, the current pixel coordinates and a once-per-frame `screenEnd` strobe. It sits between the pixel-clock divider and the pixel pipeline of the VGA controller. The controller uses `x`/`y` to address image memory and sprite logic, and uses `screenEnd` as its game-update tick.

## Interface
Parameters:
- `WIDTH`, 640, active pixels per line
- `HEIGHT`, 480, active lines per frame
- `H_FRONT_PORCH`, 16, pixels
- `H_SYNC_WIDTH`, 96, pixels
- `H_BACK_PORCH`, 48, pixels
- `V_FRONT_PORCH`, 10, lines
- `V_SYNC_WIDTH`, 2, lines
- `V_BACK_PORCH`, 33, lines

Ports:
- `clk25` in 1: pixel clock (25 MHz); the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `screenEnd` out 1: one-cycle strobe at the start of vertical blanking.
- `active` out 1: high while the current pixel is inside the visible area.
- `hSync` out 1: horizontal sync, active-low.
- `vSync` out 1: vertical sync, active-low.
- `x` out 10: current column, counted from the left.
- `y` out 9: current row, counted from the top.
- `frameCount` out 16: frame counter (see Configuration).

## Operation
- Derived totals: H_TOTAL = WIDTH+H_FRONT_PORCH+H_SYNC_WIDTH+H_BACK_PORCH (default 800); V_TOTAL = HEIGHT+V_FRONT_PORCH+V_SYNC_WIDTH+V_BACK_PORCH (default 525).
- hCount is a 10-bit register, 0..H_TOTAL-1. It increments every clk25 cycle and wraps to 0 after H_TOTAL-1.
- vCount is a 10-bit register, 0..V_TOTAL-1. It increments when hCount wraps, and wraps to 0 after V_TOTAL-1 on the same edge that hCount wraps.
- `x` = hCount[9:0].
- `y` = vCount[8:0], a truncation. `y` is meaningful only while `active`=1; in vertical blanking it aliases.
- `active` = (hCount < WIDTH) && (vCount < HEIGHT).
- `hSync` = 0 when WIDTH+H_FRONT_PORCH ≤ hCount < WIDTH+H_FRONT_PORCH+H_SYNC_WIDTH (default 656..751); 1 otherwise.
- `vSync` = 0 when HEIGHT+V_FRONT_PORCH ≤ vCount < HEIGHT+V_FRONT_PORCH+V_SYNC_WIDTH (default 490..491); 1 otherwise.
- `screenEnd` = 1 exactly when hCount==0 && vCount==HEIGHT. This gives one pulse per frame, between the last visible pixel and the next frame.
- While `reset`=0:
  - counters are cleared to 0;
  - outputs are forced: `active`=0, `hSync`=1, `vSync`=1, `screenEnd`=0, `x`=0, `y`=0;
  - `frameCount` is cleared to 0.

## Timing
- All outputs decode combinationally from the registered counters. Latency is zero relative to counter state, and there is no pipeline.
- First rising clk25 edge with `reset` high: counters hold (0,0) and outputs show x=0, y=0, active=1. Counting starts on the following edge.
- Line period is H_TOTAL cycles; frame period is H_TOTAL×V_TOTAL = 420000 cycles.
- Reset asserted mid-frame: counters clear immediately (asynchronous). After release, the frame restarts at pixel (0,0). No partial-frame `screenEnd` is generated.
- Parameter changes require resynthesis; no runtime configuration.

## Configuration
- Macro `VGA_FRAME_COUNT_EN`.
- Defined:
  - `frameCount` is a 16-bit register that increments by 1 on every clk25 edge where `screenEnd`=1.
  - It wraps 65535→0 and resets to 0.
- Undefined: `frameCount` is tied to constant 0 and no counter logic is synthesized.

## Test plan
- Reset held low for 10 cycles → active=0, hSync=1, vSync=1, screenEnd=0, x=0, y=0, frameCount=0. Release → x increments 0,1,2… from the second edge.
- First line after release → active falls when x=640; hSync low for cycles with x=656..751; line length 800 cycles, with y going 0→1 when x wraps 799→0.
- Full frame → screenEnd high for exactly 1 cycle at x=0,y=480 (cycle 384000 after counting starts) and again 420000 cycles later; vSync low for exactly 1600 cycles (lines 490–491).
- Vertical wrap → at hCount=799, vCount=524 the next cycle is (0,0) with active=1.
- Reset asserted at x=300,y=200 → outputs forced immediately. After release, timing restarts at (0,0), and the next screenEnd comes 384000 cycles later.
- With `VGA_FRAME_COUNT_EN` defined, run 3 frames → frameCount=3. Without the macro, frameCount stays 0 throughout.
